// File: rtl/mem_port_arbiter_pkg.sv
// Shared memory geometry and arbiter state encodings used by the memory-port
// arbiter and, later, the I/O bus arbiter.
package mem_port_arbiter_pkg;

   localparam int MEM_WIDTH = 16;
   localparam int ADDR_SIZE = 16;
   localparam int MEM_DEPTH = 1 << ADDR_SIZE;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   // A one-requester arbiter still needs a 1-bit pointer to stay a legal vector.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N. Returns the winner as one-hot and as an index.
module rr_picker
   import mem_port_arbiter_pkg::*;
#(
   parameter int N = 3,
   localparam int PW = ptr_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  winner,
   output logic [PW-1:0] idx
);

   // Rank each requester by its circular distance from ptr; the nearest set
   // request wins. A best distance of N means nothing was requesting.
   always_comb begin
      int best;
      int best_d;
      int d;
      best   = 0;
      best_d = N;
      d      = 0;
      winner = '0;
      for (int i = 0; i < N; i++) begin
         d = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + N - int'(ptr));
         if (req[i] && (d < best_d)) begin
            best_d = d;
            best   = i;
         end
      end
      for (int i = 0; i < N; i++) begin
         winner[i] = (best_d < N) && (best == i);
      end
      idx = PW'(best);
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between NUM_REQ requesters
// with a req/gnt/done handshake; one access every two cycles.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = ADDR_SIZE,
   parameter int DATA_W  = MEM_WIDTH
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        we,
   input  logic [NUM_REQ*ADDR_W-1:0] addr,
   input  logic [NUM_REQ*DATA_W-1:0] wdata,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        done,
   output logic [DATA_W-1:0]         rdata,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   output logic                      mem_write,
   output logic                      mem_read,
   input  logic [DATA_W-1:0]         mem_rdata
);

   localparam int PW = ptr_width(NUM_REQ);

   arb_state_t          state;
   logic [PW-1:0]       rr_ptr;
   logic [NUM_REQ-1:0]  win;
   logic [PW-1:0]       win_idx;
   logic [PW-1:0]       next_ptr;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic                sel_we;

   rr_picker #(.N(NUM_REQ)) u_picker (
      .req    (req),
      .ptr    (rr_ptr),
      .winner (win),
      .idx    (win_idx)
   );

   // Select the winner's payload with a one-hot mux so no index arithmetic
   // depends on NUM_REQ being a power of two.
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_we    = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win[i]) begin
            sel_addr  = addr[i*ADDR_W +: ADDR_W];
            sel_wdata = wdata[i*DATA_W +: DATA_W];
            sel_we    = we[i];
         end
      end
      next_ptr = (win_idx == PW'(NUM_REQ - 1)) ? '0 : (win_idx + 1'b1);
   end

   assign rdata = mem_rdata;

   // Requests are only looked at in IDLE and RESP; the grant moves to done on
   // the CMD edge, when the memory itself samples the strobes. mem_addr and
   // mem_wdata are left holding after the access since the strobes gate them.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         gnt       <= '0;
         done      <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_write <= 1'b0;
         mem_read  <= 1'b0;
      end else begin
         case (state)
            IDLE, RESP: begin
               done <= '0;
               if (|req) begin
                  gnt       <= win;
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_wdata;
                  mem_write <= sel_we;
                  mem_read  <= ~sel_we;
                  rr_ptr    <= next_ptr;
                  state     <= CMD;
               end else begin
                  state <= IDLE;
               end
            end
            CMD: begin
               gnt       <= '0;
               mem_write <= 1'b0;
               mem_read  <= 1'b0;
               done      <= gnt;
               state     <= RESP;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
